fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter BITS_PER_PIXEL, default 4, pixel data width.
REQ-002 SHALL have parameter FRAMEBUFFER_DEPTH, default 307200 (640*480), number of valid pixel addresses.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per grant before a forced hand-over.
REQ-004 SHALL have port i_Clock, input, 1 bit, sole clock; all logic is rising-edge.
REQ-005 SHALL have port i_Reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have ports i_Req0_Valid, i_Req1_Valid, input, 1 bit each, a write beat is offered.
REQ-007 SHALL have ports i_Req0_Addr, i_Req1_Addr, input, 32 bits each, pixel address.
REQ-008 SHALL have ports i_Req0_Data, i_Req1_Data, input, BITS_PER_PIXEL each, pixel value.
REQ-009 SHALL have ports i_Req0_Last, i_Req1_Last, input, 1 bit each, marks the final beat of a burst.
REQ-010 SHALL have ports o_Req0_Ready, o_Req1_Ready, output, 1 bit each; a beat is accepted when Valid and Ready are both high.
REQ-011 SHALL have ports o_Write_Enable, o_Write_Addr (32), o_Write_Data (BITS_PER_PIXEL), output, framebuffer write port.
REQ-012 SHALL have port o_Grant, output, 2 bits, one-hot current owner (00 when idle).
REQ-013 SHALL have port o_Addr_Error, output, 1 bit, one-cycle pulse per dropped out-of-range beat.

Function
REQ-014 SHALL implement states s_IDLE, s_GRANT0 and s_GRANT1.
REQ-015 SHALL, in s_IDLE with exactly one Valid high, move to that requester's grant state on the next edge.
REQ-016 SHALL, in s_IDLE with both Valid high, grant the requester named by a 1-bit round-robin pointer (reset value 0).
REQ-017 SHALL drive o_ReqN_Ready high only in s_GRANTN; Ready is a function of state only, never of Valid.
REQ-018 SHALL register each accepted beat onto the write port on the next edge, with a fixed latency of 1 cycle; o_Write_Enable SHALL be low in every cycle not following an accepted beat.
REQ-019 SHALL count accepted beats per grant, 0 to MAX_BURST-1, and clear the count on every grant change.
REQ-020 SHALL end a burst when the accepted beat has Last high or is beat number MAX_BURST.
REQ-021 SHALL, at burst end, set the pointer to the other requester; if the other Valid is high the next state is the other grant, otherwise s_IDLE.
REQ-022 SHALL keep the grant and insert no write while the owner deasserts Valid mid-burst; the other requester waits.
REQ-023 SHALL never grant both requesters in the same cycle; o_Grant SHALL be one-hot or zero.
REQ-024 SHALL accept a Last beat arriving with count already at MAX_BURST-1 as a single burst end, with no double hand-over.

Reset
REQ-025 SHALL, while i_Reset is high at an edge, force s_IDLE, pointer 0, beat count 0, and drive o_Write_Enable, o_Write_Addr, o_Write_Data, o_Grant, o_Addr_Error and both Ready outputs to 0.
REQ-026 SHALL discard any registered beat pending when reset occurs mid-burst; no write issues in the cycle after reset deasserts.

Configuration
REQ-027 SHALL, when macro FB_ARB_BOUNDS_CHECK_EN is defined, accept beats with address >= FRAMEBUFFER_DEPTH but suppress their write (o_Write_Enable low) and pulse o_Addr_Error 1 cycle later. These beats still count toward the burst.
REQ-028 SHALL, when FB_ARB_BOUNDS_CHECK_EN is undefined, pass all addresses unchecked and tie o_Addr_Error to 0.

Structure
REQ-029 SHALL take the state encodings, the requester index constants and the default FRAMEBUFFER_DEPTH from shared package framebuffer_pkg.
REQ-030 SHALL place the round-robin pick (pointer plus two Valid inputs giving a one-hot winner) in sub-module fb_rr_pick; the FSM, counter and output register stay in fb_write_arbiter.

Verification
REQ-031 Req0 only, 3 beats at addresses 5, 6, 7 with Last on 7 -> writes at 5, 6, 7 on the cycles after acceptance, o_Grant=01, then s_IDLE.
REQ-032 Both Valid in s_IDLE after reset -> Req0 granted first; after Req0 Last, Req1 granted directly with no idle cycle.
REQ-033 Req0 streams 40 beats with no Last while Req1 is valid -> hand-over after beat 16 to Req1, and Req1 runs up to 16 beats before Req0 regains the grant.
REQ-034 With bounds check enabled, beat at address 307200 -> no write, o_Addr_Error pulses 1 cycle later; a beat at address 307199 writes normally.
REQ-035 i_Reset asserted on the cycle after the 2nd accepted beat of a burst -> no write at the next edge, all outputs 0, and a new request is granted normally after reset deasserts.
REQ-036 Owner drops Valid for 3 cycles mid-burst -> o_Grant unchanged, no writes in those cycles, and the burst resumes when Valid returns.

Source files
------------

// File: rtl/framebuffer_pkg.sv
// Shared types and constants for the framebuffer write path.
package framebuffer_pkg;

   typedef enum logic [1:0] {
      s_IDLE   = 2'd0,
      s_GRANT0 = 2'd1,
      s_GRANT1 = 2'd2
   } arb_state_e;

   localparam logic REQ0_IDX = 1'b0;
   localparam logic REQ1_IDX = 1'b1;

   localparam int FB_DEPTH_DEFAULT = 640 * 480;

   // The requester that should be favoured after the given one finishes a burst.
   function automatic logic other_req(input logic idx);
      return ~idx;
   endfunction

endpackage

// File: rtl/fb_rr_pick.sv
// Round-robin pick between two requesters; the pointer only breaks ties.
module fb_rr_pick
   import framebuffer_pkg::*;
(
   input  logic       ptr_i,
   input  logic       valid0_i,
   input  logic       valid1_i,
   output logic [1:0] winner_o
);

   always_comb begin
      winner_o = 2'b00;
      if (valid0_i && valid1_i) begin
         winner_o = (ptr_i == REQ0_IDX) ? 2'b01 : 2'b10;
      end else begin
         winner_o = {valid1_i, valid0_i};
      end
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Two-requester burst arbiter in front of a framebuffer write port.
// Optional out-of-range address filtering is enabled by FB_ARB_BOUNDS_CHECK_EN.
module fb_write_arbiter
   import framebuffer_pkg::*;
#(
   parameter int BITS_PER_PIXEL    = 4,
   parameter int FRAMEBUFFER_DEPTH = FB_DEPTH_DEFAULT,
   parameter int MAX_BURST         = 16
)(
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic                      i_Req0_Valid,
   input  logic [31:0]               i_Req0_Addr,
   input  logic [BITS_PER_PIXEL-1:0] i_Req0_Data,
   input  logic                      i_Req0_Last,
   input  logic                      i_Req1_Valid,
   input  logic [31:0]               i_Req1_Addr,
   input  logic [BITS_PER_PIXEL-1:0] i_Req1_Data,
   input  logic                      i_Req1_Last,
   output logic                      o_Req0_Ready,
   output logic                      o_Req1_Ready,
   output logic                      o_Write_Enable,
   output logic [31:0]               o_Write_Addr,
   output logic [BITS_PER_PIXEL-1:0] o_Write_Data,
   output logic [1:0]                o_Grant,
   output logic                      o_Addr_Error
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_e                state_q, state_d;
   logic                      ptr_q, ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic                      wrEn_q, wrEn_d;
   logic [31:0]               wrAddr_q, wrAddr_d;
   logic [BITS_PER_PIXEL-1:0] wrData_q, wrData_d;
   logic                      addrErr_q, addrErr_d;

   logic [1:0]                winner;
   logic                      ownValid;
   logic                      ownLast;
   logic                      otherValid;
   logic [31:0]               ownAddr;
   logic [BITS_PER_PIXEL-1:0] ownData;
   logic                      accept;
   logic                      burstEnd;
   logic                      inRange;

   fb_rr_pick u_pick (
      .ptr_i    (ptr_q),
      .valid0_i (i_Req0_Valid),
      .valid1_i (i_Req1_Valid),
      .winner_o (winner)
   );

   assign o_Req0_Ready = (state_q == s_GRANT0);
   assign o_Req1_Ready = (state_q == s_GRANT1);
   assign o_Grant      = {o_Req1_Ready, o_Req0_Ready};

   assign ownValid   = (state_q == s_GRANT1) ? i_Req1_Valid : i_Req0_Valid;
   assign ownLast    = (state_q == s_GRANT1) ? i_Req1_Last  : i_Req0_Last;
   assign ownAddr    = (state_q == s_GRANT1) ? i_Req1_Addr  : i_Req0_Addr;
   assign ownData    = (state_q == s_GRANT1) ? i_Req1_Data  : i_Req0_Data;
   assign otherValid = (state_q == s_GRANT1) ? i_Req0_Valid : i_Req1_Valid;

   assign accept   = (o_Req0_Ready || o_Req1_Ready) && ownValid;
   // A Last on the final allowed beat is still one burst end, not two.
   assign burstEnd = accept && (ownLast || (count_q == CNT_LAST));

`ifdef FB_ARB_BOUNDS_CHECK_EN
   assign inRange = (ownAddr < 32'(FRAMEBUFFER_DEPTH));
`else
   assign inRange = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      case (state_q)
         s_IDLE: begin
            count_d = '0;
            if (winner[0]) begin
               state_d = s_GRANT0;
            end else if (winner[1]) begin
               state_d = s_GRANT1;
            end
         end
         s_GRANT0, s_GRANT1: begin
            if (burstEnd) begin
               count_d = '0;
               ptr_d   = (state_q == s_GRANT0) ? other_req(REQ0_IDX) : other_req(REQ1_IDX);
               if (otherValid) begin
                  state_d = (state_q == s_GRANT0) ? s_GRANT1 : s_GRANT0;
               end else begin
                  state_d = s_IDLE;
               end
            end else if (accept) begin
               count_d = count_q + 1'b1;
            end
         end
         default: begin
            state_d = s_IDLE;
            count_d = '0;
         end
      endcase
   end

   always_comb begin
      wrEn_d    = accept && inRange;
      addrErr_d = accept && !inRange;
      wrAddr_d  = wrAddr_q;
      wrData_d  = wrData_q;
      if (accept) begin
         wrAddr_d = ownAddr;
         wrData_d = ownData;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q   <= s_IDLE;
         ptr_q     <= REQ0_IDX;
         count_q   <= '0;
         wrEn_q    <= 1'b0;
         wrAddr_q  <= '0;
         wrData_q  <= '0;
         addrErr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         wrEn_q    <= wrEn_d;
         wrAddr_q  <= wrAddr_d;
         wrData_q  <= wrData_d;
         addrErr_q <= addrErr_d;
      end
   end

   assign o_Write_Enable = wrEn_q;
   assign o_Write_Addr   = wrAddr_q;
   assign o_Write_Data   = wrData_q;

`ifdef FB_ARB_BOUNDS_CHECK_EN
   assign o_Addr_Error = addrErr_q;
`else
   assign o_Addr_Error = 1'b0;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter.
// Expected values for out-of-range beats follow FB_ARB_BOUNDS_CHECK_EN.
module tb_fb_write_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        v0, v1, l0, l1;
   logic [31:0] a0, a1;
   logic [3:0]  d0, d1;
   logic        rdy0, rdy1, we, aerr;
   logic [31:0] wa;
   logic [3:0]  wd;
   logic [1:0]  grant;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   fb_write_arbiter dut (
      .i_Clock        (clock),
      .i_Reset        (reset),
      .i_Req0_Valid   (v0),
      .i_Req0_Addr    (a0),
      .i_Req0_Data    (d0),
      .i_Req0_Last    (l0),
      .i_Req1_Valid   (v1),
      .i_Req1_Addr    (a1),
      .i_Req1_Data    (d1),
      .i_Req1_Last    (l1),
      .o_Req0_Ready   (rdy0),
      .o_Req1_Ready   (rdy1),
      .o_Write_Enable (we),
      .o_Write_Addr   (wa),
      .o_Write_Data   (wd),
      .o_Grant        (grant),
      .o_Addr_Error   (aerr)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic iv0, input logic [31:0] ia0, input logic [3:0] id0, input logic il0,
                                input logic iv1, input logic [31:0] ia1, input logic [3:0] id1, input logic il1);
      v0 = iv0; a0 = ia0; d0 = id0; l0 = il0;
      v1 = iv1; a1 = ia1; d1 = id1; l1 = il1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic checkWrite(input string tag, input logic [31:0] addr, input logic [3:0] data);
      checkOutput({tag, "_we"}, 64'(we), 64'(1));
      checkOutput({tag, "_addr"}, 64'(wa), 64'(addr));
      checkOutput({tag, "_data"}, 64'(wd), 64'(data));
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      // Reset state of every output
      checkOutput("rst_we", 64'(we), 64'(0));
      checkOutput("rst_grant", 64'(grant), 64'(0));
      checkOutput("rst_rdy0", 64'(rdy0), 64'(0));
      checkOutput("rst_rdy1", 64'(rdy1), 64'(0));
      checkOutput("rst_aerr", 64'(aerr), 64'(0));
      checkOutput("rst_addr", 64'(wa), 64'(0));
      reset = 1'b0;

      // Single requester, three-beat burst
      applyStimulus(1, 5, 4'h1, 0, 0, 0, 0, 0);
      tick();
      checkOutput("s1_grant", 64'(grant), 64'(2'b01));
      checkOutput("s1_rdy0", 64'(rdy0), 64'(1));
      checkOutput("s1_we0", 64'(we), 64'(0));
      tick();
      checkWrite("s1_b5", 5, 4'h1);
      applyStimulus(1, 6, 4'h2, 0, 0, 0, 0, 0);
      tick();
      checkWrite("s1_b6", 6, 4'h2);
      applyStimulus(1, 7, 4'h3, 1, 0, 0, 0, 0);
      tick();
      checkWrite("s1_b7", 7, 4'h3);
      checkOutput("s1_idle_grant", 64'(grant), 64'(0));
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("s1_we_after", 64'(we), 64'(0));

      // Both valid after reset: req0 first, then req1 with no idle gap
      doReset();
      applyStimulus(1, 10, 4'hA, 1, 1, 20, 4'hB, 1);
      tick();
      checkOutput("s2_grant0", 64'(grant), 64'(2'b01));
      checkOutput("s2_rdy1", 64'(rdy1), 64'(0));
      tick();
      checkWrite("s2_w10", 10, 4'hA);
      checkOutput("s2_grant1", 64'(grant), 64'(2'b10));
      applyStimulus(0, 0, 0, 0, 1, 20, 4'hB, 1);
      tick();
      checkWrite("s2_w20", 20, 4'hB);
      checkOutput("s2_idle", 64'(grant), 64'(0));
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("s2_we_after", 64'(we), 64'(0));

      // Owner stalls mid-burst while req1 waits
      doReset();
      applyStimulus(1, 100, 4'h4, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkWrite("s3_w100", 100, 4'h4);
      applyStimulus(0, 0, 0, 0, 1, 50, 4'h5, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("s3_stall_we%0d", i), 64'(we), 64'(0));
         checkOutput($sformatf("s3_stall_grant%0d", i), 64'(grant), 64'(2'b01));
      end
      applyStimulus(1, 101, 4'h6, 1, 1, 50, 4'h5, 1);
      tick();
      checkWrite("s3_w101", 101, 4'h6);
      checkOutput("s3_handover", 64'(grant), 64'(2'b10));
      applyStimulus(0, 0, 0, 0, 1, 50, 4'h5, 1);
      tick();
      checkWrite("s3_w50", 50, 4'h5);
      checkOutput("s3_idle", 64'(grant), 64'(0));
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Forced hand-over after 16 beats in both directions
      doReset();
      applyStimulus(1, 1000, 4'h0, 0, 1, 2000, 4'h0, 0);
      tick();
      checkOutput("s4_grant0", 64'(grant), 64'(2'b01));
      for (int i = 0; i < 16; i++) begin
         a0 = 32'(1000 + i);
         d0 = 4'(i);
         tick();
         checkWrite($sformatf("s4_r0b%0d", i), 32'(1000 + i), 4'(i));
      end
      checkOutput("s4_grant1", 64'(grant), 64'(2'b10));
      checkOutput("s4_rdy0_low", 64'(rdy0), 64'(0));
      for (int j = 0; j < 16; j++) begin
         a1 = 32'(2000 + j);
         d1 = 4'(15 - j);
         tick();
         checkWrite($sformatf("s4_r1b%0d", j), 32'(2000 + j), 4'(15 - j));
      end
      checkOutput("s4_regrant0", 64'(grant), 64'(2'b01));
      a0 = 1016;
      d0 = 4'h7;
      tick();
      checkWrite("s4_r0b16", 1016, 4'h7);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // Last on beat 16 is a single hand-over
      doReset();
      applyStimulus(1, 500, 4'h1, 0, 1, 600, 4'h2, 1);
      tick();
      for (int i = 0; i < 15; i++) tick();
      l0 = 1'b1;
      tick();
      checkOutput("s5_grant1", 64'(grant), 64'(2'b10));
      tick();
      checkWrite("s5_w600", 600, 4'h2);
      checkOutput("s5_grant0", 64'(grant), 64'(2'b01));
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Out-of-range and last-valid address
      doReset();
      applyStimulus(1, 307200, 4'h9, 0, 0, 0, 0, 0);
      tick();
      tick();
`ifdef FB_ARB_BOUNDS_CHECK_EN
      checkOutput("s6_oor_we", 64'(we), 64'(0));
      checkOutput("s6_oor_err", 64'(aerr), 64'(1));
`else
      checkOutput("s6_oor_we", 64'(we), 64'(1));
      checkOutput("s6_oor_err", 64'(aerr), 64'(0));
`endif
      applyStimulus(1, 307199, 4'h8, 1, 0, 0, 0, 0);
      tick();
      checkWrite("s6_inr", 307199, 4'h8);
      checkOutput("s6_inr_err", 64'(aerr), 64'(0));
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Reset in the cycle after the second accepted beat
      doReset();
      applyStimulus(1, 300, 4'h3, 0, 0, 0, 0, 0);
      tick();
      tick();
      a0 = 301;
      tick();
      checkWrite("s7_w301", 301, 4'h3);
      a0 = 302;
      reset = 1'b1;
      tick();
      checkOutput("s7_rst_we", 64'(we), 64'(0));
      checkOutput("s7_rst_grant", 64'(grant), 64'(0));
      checkOutput("s7_rst_rdy0", 64'(rdy0), 64'(0));
      checkOutput("s7_rst_addr", 64'(wa), 64'(0));
      checkOutput("s7_rst_data", 64'(wd), 64'(0));
      reset = 1'b0;
      tick();
      checkOutput("s7_post_we", 64'(we), 64'(0));
      checkOutput("s7_post_grant", 64'(grant), 64'(2'b01));
      tick();
      checkWrite("s7_w302", 302, 4'h3);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
